// File: rtl/icache_lookup_if.sv
// Downstream fetch-offer bus: {pc, hit, line, prediction} with valid/ready handshake.
// The master drives the offer; the slave returns ready.
interface icache_lookup_if;
    logic         valid_post_o;
    logic         ready_post_i;
    logic [31:0]  araddr_o;
    logic         tar_hit_o;
    logic [127:0] buffer_o;
    logic         pvalid_o;
    logic         ptaken_o;
    logic [31:0]  ptarget_o;

    modport master (
        output valid_post_o, araddr_o, tar_hit_o, buffer_o, pvalid_o, ptaken_o, ptarget_o,
        input  ready_post_i
    );

    modport slave (
        input  valid_post_o, araddr_o, tar_hit_o, buffer_o, pvalid_o, ptaken_o, ptarget_o,
        output ready_post_i
    );
endinterface

// File: rtl/icache_lookup.sv
// Fetch-pipe head: owns the PC and the 8-set x NWAY-way I$ arrays, looks up the current PC
// combinationally, attaches the BPU prediction and offers the result downstream.
module icache_lookup #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000,
    parameter int          NWAY     = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    icache_lookup_if.master      post,
    output logic [31:0]          bpu_pc_o,
    input  logic                 bpu_valid_i,
    input  logic                 bpu_taken_i,
    input  logic [31:0]          bpu_target_i,
    input  logic                 flush_i,
    input  logic [31:0]          flush_target_i,
    input  logic                 csr_flush_i,
    input  logic [31:0]          csr_target_i,
    input  logic                 fencei_i,
    input  logic                 wen_i,
    input  logic [2:0]           windex_i,
    input  logic [2:0]           wway_i,
    input  logic [24:0]          wtag_i,
    input  logic [127:0]         wdata_i
);

    logic [31:0]              pc_q, pc_d;
    logic [7:0][NWAY-1:0]     valid_q, valid_d;
    logic [24:0]              tag_q  [8][NWAY];
    logic [127:0]             data_q [8][NWAY];

    logic [24:0]              pc_tag;
    logic [2:0]               pc_index;
    logic [NWAY-1:0]          hit_vec;
    logic                     hit;
    logic [127:0]             line;
    logic                     bypass;
    logic                     valid_post;
    logic                     ptaken;
    logic [31:0]              ptarget;
    logic                     fire;

    assign pc_tag   = pc_q[31:7];
    assign pc_index = pc_q[6:4];

    // Ways are one-hot by construction, so the hit line is an AND-OR of the set.
    always_comb begin
        hit_vec = '0;
        line    = '0;
        for (int w = 0; w < NWAY; w++) begin
            hit_vec[w] = valid_q[pc_index][w] && (tag_q[pc_index][w] == pc_tag);
            line       = line | ({128{hit_vec[w]}} & data_q[pc_index][w]);
        end
    end

    // A refill for the line being looked up is forwarded in the same cycle.
    assign bypass = wen_i && (windex_i == pc_index) && (wtag_i == pc_tag);
    assign hit    = bypass || (|hit_vec);

    assign valid_post = !(reset || flush_i || csr_flush_i || fencei_i);
    assign ptaken     = bpu_valid_i && bpu_taken_i;
    assign ptarget    = {bpu_target_i[31:2], 2'b00};
    assign fire       = valid_post && post.ready_post_i;

    assign post.valid_post_o = valid_post;
    assign post.araddr_o     = pc_q;
    assign post.tar_hit_o    = hit;
    assign post.buffer_o     = bypass ? wdata_i : line;
    assign post.pvalid_o     = bpu_valid_i;
    assign post.ptaken_o     = ptaken;
    assign post.ptarget_o    = ptarget;
    assign bpu_pc_o          = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (csr_flush_i) begin
            pc_d = {csr_target_i[31:2], 2'b00};
        end else if (flush_i) begin
            pc_d = {flush_target_i[31:2], 2'b00};
        end else if (fire) begin
            pc_d = ptaken ? ptarget : pc_q + 32'd4;
        end
    end

    // Fence wins over a coincident refill: the written way stays invalid.
    always_comb begin
        valid_d = valid_q;
        if (fencei_i) begin
            valid_d = '0;
        end else if (wen_i) begin
            valid_d[windex_i][wway_i] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            valid_q <= '0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wen_i && !reset) begin
            tag_q[windex_i][wway_i]  <= wtag_i;
            data_q[windex_i][wway_i] <= wdata_i;
        end
    end

    a_onehot_hit: assert property (@(posedge clock) disable iff (reset) $onehot0(hit_vec));

endmodule
